// File: rtl/bias_argmax_head.sv
// Final classifier stage: adds per-channel bias to each accumulator result and emits the argmax channel.
// Latency: result valid the cycle after the last channel transfer; in_ready drops while a result waits on out_ready.
// Optional BIAS_ARGMAX_SCORE_EN exposes the winning biased sum on max_score.
module bias_argmax_head #(
    parameter int PE_OUT_WIDTH        = 24,
    parameter int DATA_WIDTH          = 8,
    parameter int OUTPUT_CHANNEL      = 10,
    parameter int BIAS_MEM_DATA_WIDTH = DATA_WIDTH * OUTPUT_CHANNEL,
    parameter int IDX_WIDTH           = $clog2(OUTPUT_CHANNEL)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [BIAS_MEM_DATA_WIDTH-1:0] bias_vec,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PE_OUT_WIDTH-1:0]        in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_WIDTH-1:0]           number,
    output logic                           busy
`ifdef BIAS_ARGMAX_SCORE_EN
    ,
    output logic signed [PE_OUT_WIDTH:0]   max_score
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_CH = IDX_WIDTH'(OUTPUT_CHANNEL - 1);

    state_t                           state_q;
    logic [BIAS_MEM_DATA_WIDTH-1:0]   bias_q;
    logic [IDX_WIDTH-1:0]             ch_q;
    logic [IDX_WIDTH-1:0]             best_q;
    logic [IDX_WIDTH-1:0]             number_q;
    logic signed [PE_OUT_WIDTH:0]     max_q;
    logic                             max_valid_q;

    logic [DATA_WIDTH-1:0]            bias_sel;
    logic signed [PE_OUT_WIDTH:0]     in_ext;
    logic signed [PE_OUT_WIDTH:0]     bias_ext;
    logic signed [PE_OUT_WIDTH:0]     sum_d;
    logic                             take_d;
    logic                             do_start;

    // One extra bit of headroom makes the biased sum overflow-free.
    assign bias_sel = bias_q[ch_q*DATA_WIDTH +: DATA_WIDTH];
    assign in_ext   = {in_data[PE_OUT_WIDTH-1], in_data};
    assign bias_ext = {{(PE_OUT_WIDTH+1-DATA_WIDTH){bias_sel[DATA_WIDTH-1]}}, bias_sel};
    assign sum_d    = in_ext + bias_ext;
    assign take_d   = !max_valid_q || (sum_d > max_q);

    // A start in RESULT only counts when the pending result is being consumed.
    assign do_start = start && ((state_q != RESULT) || out_ready);

`ifdef BIAS_ARGMAX_SCORE_EN
    logic signed [PE_OUT_WIDTH:0] score_q;
    assign max_score = score_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bias_q      <= '0;
            ch_q        <= '0;
            best_q      <= '0;
            number_q    <= '0;
            max_q       <= '0;
            max_valid_q <= 1'b0;
`ifdef BIAS_ARGMAX_SCORE_EN
            score_q     <= '0;
`endif
        end else if (do_start) begin
            state_q     <= ACCUM;
            bias_q      <= bias_vec;
            ch_q        <= '0;
            max_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (take_d) begin
                            max_q  <= sum_d;
                            best_q <= ch_q;
                        end
                        max_valid_q <= 1'b1;
                        if (ch_q == LAST_CH) begin
                            state_q  <= RESULT;
                            number_q <= take_d ? ch_q : best_q;
`ifdef BIAS_ARGMAX_SCORE_EN
                            score_q  <= take_d ? sum_d : max_q;
`endif
                        end else begin
                            ch_q <= ch_q + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign number    = number_q;

endmodule

// File: tb/tb_bias_argmax_head.sv
// Directed-vector bench for bias_argmax_head with hand-computed winners and scores.
module tb_bias_argmax_head;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [79:0] bias_vec;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  number;
    logic        busy;
`ifdef BIAS_ARGMAX_SCORE_EN
    logic signed [24:0] max_score;
`endif

    int errors = 0;
    int checks = 0;
    logic [23:0] din [10];

    bias_argmax_head dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bias_vec  (bias_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .number    (number),
        .busy      (busy)
`ifdef BIAS_ARGMAX_SCORE_EN
        ,
        .max_score (max_score)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [79:0] bias_all(input logic [7:0] v);
        logic [79:0] b;
        for (int k = 0; k < 10; k++) b[k*8 +: 8] = v;
        return b;
    endfunction

    function automatic logic [79:0] bias_one(input int k, input logic [7:0] v);
        logic [79:0] b;
        b = '0;
        b[k*8 +: 8] = v;
        return b;
    endfunction

    task automatic check_score(input string tag, input int exp);
`ifdef BIAS_ARGMAX_SCORE_EN
        check(tag, 32'($signed(max_score)), 32'(exp));
`endif
    endtask

    // Start pulse carries a junk valid beat that must be ignored; idle beats also carry junk.
    task automatic frame(input string tag, input logic [79:0] b, input bit toggle,
                         input int exp_num, input int exp_score);
        @(negedge clk);
        start = 1'b1; bias_vec = b; in_valid = 1'b1; in_data = 24'h7FFFFF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = din[i];
            if (i == 0) check({tag, " in_ready"}, 32'(in_ready), 32'd1);
            if (i == 9) check({tag, " no early out_valid"}, 32'(out_valid), 32'd0);
            @(negedge clk);
            if (toggle && i != 9) begin
                in_valid = 1'b0;
                in_data  = 24'h7FFFFF;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " in_ready low"}, 32'(in_ready), 32'd0);
        check({tag, " number"}, 32'(number), 32'(exp_num));
        check_score({tag, " score"}, exp_score);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    task automatic set_a();
        din = '{24'd5, 24'd3, 24'd9, 24'd1, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd2};
    endtask

    initial begin
        bit seen_valid;
        reset_n = 1'b0; start = 1'b0; bias_vec = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst number", 32'(number), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check_score("rst score", 0);
        reset_n = 1'b1;

        // Basic frame, then backpressure with an ignored start.
        set_a();
        frame("A", bias_all(8'h00), 1'b0, 2, 9);
        check("A busy", 32'(busy), 32'd1);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            bias_vec = bias_all(8'h55);
            @(negedge clk);
            check("A hold out_valid", 32'(out_valid), 32'd1);
            check("A hold number", 32'(number), 32'd2);
        end
        start = 1'b0;
        release_result("A");

        for (int i = 0; i < 10; i++) din[i] = 24'd100;
        frame("B", bias_one(7, 8'h01), 1'b0, 7, 101);

        // Start together with out_ready: result consumed and new frame begins.
        out_ready = 1'b1; start = 1'b1; bias_vec = '0;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        check("B->new busy", 32'(busy), 32'd1);
        check("B->new in_ready", 32'(in_ready), 32'd1);
        check("B->new out_valid", 32'(out_valid), 32'd0);
        check("B->new number kept", 32'(number), 32'd7);

        for (int i = 0; i < 10; i++) din[i] = 24'hFFFFCE;  // -50
        frame("C", bias_all(8'hFD), 1'b0, 0, -53);
        release_result("C");

        for (int i = 0; i < 10; i++) din[i] = 24'd10;
        din[4] = 24'd20; din[8] = 24'd20;
        frame("D", bias_all(8'h00), 1'b0, 4, 20);
        release_result("D");

        for (int i = 0; i < 10; i++) din[i] = 24'd0;
        din[9] = 24'h7FFFFF;
        frame("E", bias_one(9, 8'h7F), 1'b0, 9, 8388734);
        release_result("E");

        for (int i = 0; i < 10; i++) din[i] = 24'h800000;
        frame("F", bias_all(8'h80), 1'b0, 0, -8388736);
        release_result("F");

        set_a();
        frame("toggle", bias_all(8'h00), 1'b1, 2, 9);
        release_result("toggle");

        // Abort after 4 transfers of a frame whose ch1 would win.
        @(negedge clk);
        start = 1'b1; bias_vec = bias_all(8'h00); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 1) ? 24'h7FFFFF : 24'd1;
            @(negedge clk);
        end
        check("abort still accum", 32'(in_ready), 32'd1);
        frame("abort", bias_all(8'h00), 1'b0, 2, 9);
        release_result("abort");

        // Reset mid-frame.
        @(negedge clk);
        start = 1'b1; bias_vec = bias_all(8'h00);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 24'd7;
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst number", 32'(number), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check_score("midrst score", 0);
        reset_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = 24'd7;
            @(negedge clk);
            if (out_valid || busy) seen_valid = 1'b1;
        end
        in_valid = 1'b0;
        check("postrst stays idle", 32'(seen_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
